// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic trigger/echo sensor emulation.
// The distance driver imports the same scale factors.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } us_state_e;

    localparam int unsigned CYCLES_PER_CM   = 32'd200;
    localparam int unsigned MAX_CM          = 32'd960;
    localparam int unsigned TIMEOUT_CYCLES  = 32'd1900000;
    localparam int unsigned TRIG_MIN_CYCLES = 32'd50;

    // Echo width in cycles; a zero distance reads as 1 cm, beyond range reads as "no object".
    function automatic int unsigned echo_width(
        input logic [9:0]  dist_cm,
        input int unsigned cycles_per_cm,
        input int unsigned max_cm,
        input int unsigned timeout_cycles
    );
        int unsigned d;
        d = (dist_cm == 10'd0) ? 32'd1 : {22'd0, dist_cm};
        if (d > max_cm) begin
            echo_width = timeout_cycles;
        end else begin
            echo_width = d * cycles_per_cm;
        end
    endfunction

endpackage

// File: rtl/ultrasonic_timer.sv
// Loadable down-counter; done is high during the last cycle of the loaded interval.
module ultrasonic_timer #(
    parameter int unsigned CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Sensor-side emulation of an HC-SR04 style trigger/echo interface:
// a valid TR pulse is answered after a burst delay by an ECH pulse proportional to DIST_CM.
module ultrasonic_echo_responder #(
    parameter int unsigned CYCLES_PER_CM      = ultrasonic_pkg::CYCLES_PER_CM,
    parameter int unsigned TRIG_MIN_CYCLES    = ultrasonic_pkg::TRIG_MIN_CYCLES,
    parameter int unsigned BURST_DELAY_CYCLES = 32'd10000,
    parameter int unsigned HOLDOFF_CYCLES     = 32'd50000,
    parameter int unsigned MAX_CM             = ultrasonic_pkg::MAX_CM,
    parameter int unsigned TIMEOUT_CYCLES     = ultrasonic_pkg::TIMEOUT_CYCLES
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       TR,
    input  logic [9:0] DIST_CM,
    output logic       ECH,
    output logic       BUSY,
    output logic       SHORT_TRIG
);
    import ultrasonic_pkg::*;

    localparam int unsigned MAX_IN_RANGE = 32'd1023 * CYCLES_PER_CM;
    localparam int unsigned MAX_W = (TIMEOUT_CYCLES > MAX_IN_RANGE) ? TIMEOUT_CYCLES : MAX_IN_RANGE;
    localparam int unsigned CNT_W = $clog2(MAX_W) + 1;
    localparam int unsigned TC_W  = $clog2(TRIG_MIN_CYCLES + 1);

    localparam logic [TC_W-1:0] TRIG_MIN_C = TC_W'(TRIG_MIN_CYCLES);
    localparam logic [TC_W-1:0] TRIG_ONE   = TC_W'(1);

    us_state_e        state_q, state_d;
    logic [TC_W-1:0]  trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             tr_d_q;
    logic             ech_q, ech_d;
    logic             busy_q, busy_d;
    logic             short_trig_q, short_trig_d;
    logic             rise_s, fall_s;
    logic             timer_load_s, timer_done_s;
    logic [CNT_W-1:0] timer_val_s;

    assign rise_s = TR & ~tr_d_q;
    assign fall_s = ~TR & tr_d_q;

    ultrasonic_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (CLOCK),
        .rst      (RESET),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .done     (timer_done_s)
    );

    // State, counters and registered outputs; tr_d resets high so a held TR needs a fresh rise.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= IDLE;
            trig_cnt_q   <= {TC_W{1'b0}};
            width_q      <= {CNT_W{1'b0}};
            tr_d_q       <= 1'b1;
            ech_q        <= 1'b0;
            busy_q       <= 1'b0;
            short_trig_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_cnt_q   <= trig_cnt_d;
            width_q      <= width_d;
            tr_d_q       <= TR;
            ech_q        <= ech_d;
            busy_q       <= busy_d;
            short_trig_q <= short_trig_d;
        end
    end

    // Next-state logic; TR is only looked at in IDLE and TRIG.
    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        width_d    = width_q;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d    = TRIG;
                    trig_cnt_d = TRIG_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                if (fall_s) begin
                    if (trig_cnt_q >= TRIG_MIN_C) begin
                        state_d = BURST;
                        width_d = CNT_W'(echo_width(DIST_CM, CYCLES_PER_CM, MAX_CM, TIMEOUT_CYCLES));
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trig_cnt_q < TRIG_MIN_C) begin
                    trig_cnt_d = trig_cnt_q + TRIG_ONE;
                end else begin
                    trig_cnt_d = trig_cnt_q;
                end
            end
            BURST: begin
                if (timer_done_s) begin
                    state_d = ECHO;
                end else begin
                    state_d = BURST;
                end
            end
            ECHO: begin
                if (timer_done_s) begin
                    state_d = HOLDOFF;
                end else begin
                    state_d = ECHO;
                end
            end
            HOLDOFF: begin
                if (timer_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLDOFF;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, plus the timer reload on each timed-state entry.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = width_q;
        case (state_d)
            BURST: begin
                timer_load_s = (state_q != BURST);
                timer_val_s  = CNT_W'(BURST_DELAY_CYCLES);
            end
            ECHO: begin
                timer_load_s = (state_q != ECHO);
                timer_val_s  = width_q;
            end
            HOLDOFF: begin
                timer_load_s = (state_q != HOLDOFF);
                timer_val_s  = CNT_W'(HOLDOFF_CYCLES);
            end
            default: begin
                timer_load_s = 1'b0;
                timer_val_s  = width_q;
            end
        endcase
        ech_d        = (state_d == ECHO);
        busy_d       = (state_d == BURST) || (state_d == ECHO) || (state_d == HOLDOFF);
        short_trig_d = (state_q == TRIG) && fall_s && (trig_cnt_q < TRIG_MIN_C);
    end

    assign ECH        = ech_q;
    assign BUSY       = busy_q;
    assign SHORT_TRIG = short_trig_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Randomized bench for ultrasonic_echo_responder against a timestamp-based reference model,
// with scaled-down timing parameters so the run stays short.
module tb_ultrasonic_echo_responder;

    localparam int unsigned CPC  = 3;
    localparam int unsigned TMIN = 8;
    localparam int unsigned BD   = 20;
    localparam int unsigned HO   = 30;
    localparam int unsigned MAXC = 960;
    localparam int unsigned TMO  = 4000;

    logic       CLOCK;
    logic       RESET;
    logic       TR;
    logic [9:0] DIST_CM;
    logic       ECH, BUSY, SHORT_TRIG;

    int vectors;
    int miscompares;

    // Model state: measurement described by its fall edge index, width and end edge.
    int cyc, hi_cnt, t_fall, t_end, w_exp, short_at;
    bit act, in_trig, prev_tr, chk_en;
    bit exp_ech, exp_busy, exp_short;

    ultrasonic_echo_responder #(
        .CYCLES_PER_CM      (CPC),
        .TRIG_MIN_CYCLES    (TMIN),
        .BURST_DELAY_CYCLES (BD),
        .HOLDOFF_CYCLES     (HO),
        .MAX_CM             (MAXC),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .TR         (TR),
        .DIST_CM    (DIST_CM),
        .ECH        (ECH),
        .BUSY       (BUSY),
        .SHORT_TRIG (SHORT_TRIG)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_width(input logic [9:0] d);
        int dd;
        dd = (d == 10'd0) ? 1 : int'(d);
        return (dd > int'(MAXC)) ? int'(TMO) : dd * int'(CPC);
    endfunction

    // Reference model: on each edge decide trigger validity and derive expected outputs from timestamps.
    initial begin
        cyc = 0; act = 1'b0; in_trig = 1'b0; prev_tr = 1'b1; short_at = -1;
        hi_cnt = 0; t_fall = 0; t_end = 0; w_exp = 0; chk_en = 1'b0;
        vectors = 0; miscompares = 0;
    end

    always @(posedge CLOCK) begin
        cyc = cyc + 1;
        chk_en = 1'b1;
        if (RESET) begin
            act = 1'b0; in_trig = 1'b0; prev_tr = 1'b1; short_at = -1;
        end else begin
            if (in_trig) begin
                if (TR) begin
                    hi_cnt = hi_cnt + 1;
                end else begin
                    in_trig = 1'b0;
                    if (hi_cnt >= int'(TMIN)) begin
                        act    = 1'b1;
                        t_fall = cyc;
                        w_exp  = ref_width(DIST_CM);
                        t_end  = t_fall + int'(BD) + w_exp + int'(HO);
                    end else begin
                        short_at = cyc;
                    end
                end
            end else if (!act || cyc > t_end) begin
                if (TR && !prev_tr) begin
                    in_trig = 1'b1;
                    hi_cnt  = 1;
                end
            end
            prev_tr = TR;
        end
        exp_busy  = act && (cyc >= t_fall) && (cyc < t_end);
        exp_ech   = act && (cyc >= t_fall + int'(BD)) && (cyc < t_fall + int'(BD) + w_exp);
        exp_short = (short_at == cyc);
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            check_eq("ech_busy_short", {29'd0, ECH, BUSY, SHORT_TRIG},
                     {29'd0, exp_ech, exp_busy, exp_short});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic trig_pulse(input int len, input logic [9:0] d);
        DIST_CM = d;
        TR = 1'b1;
        tick(len);
        TR = 1'b0;
        tick(1);
    endtask

    // Wait for the model to go idle; optionally hammer TR and DIST_CM while busy.
    task automatic wait_idle(input bit abuse);
        int n;
        n = 0;
        while ((in_trig || (act && cyc <= t_end)) && n < 20000) begin
            if (abuse && act && cyc + 2 < t_end) begin
                if ($urandom_range(0, 11) == 0) TR = ~TR;
                DIST_CM = 10'($urandom);
            end else begin
                TR = 1'b0;
            end
            tick(1);
            n++;
        end
        check_eq("idle_bound", {31'd0, (n < 20000)}, 32'd1);
        TR = 1'b0;
        tick(3);
    endtask

    initial begin
        int n;
        RESET = 1'b1; TR = 1'b0; DIST_CM = 10'd0;
        tick(3);
        check_eq("reset_outs", {29'd0, ECH, BUSY, SHORT_TRIG}, 32'd0);
        RESET = 1'b0;
        tick(2);

        // Minimum valid pulse, short pulses, range boundaries.
        trig_pulse(TMIN, 10'd25);      wait_idle(1'b0);
        trig_pulse(5, 10'd25);         wait_idle(1'b0);
        trig_pulse(TMIN - 1, 10'd25);  wait_idle(1'b0);
        trig_pulse(10, 10'd1000);      wait_idle(1'b0);
        trig_pulse(10, 10'd0);         wait_idle(1'b0);
        trig_pulse(10, 10'd960);       wait_idle(1'b0);
        trig_pulse(10, 10'd961);       wait_idle(1'b0);

        // Distance changes and TR activity while busy are ignored.
        trig_pulse(10, 10'd25);        wait_idle(1'b1);

        // TR held high across the end of HOLDOFF is not a trigger.
        trig_pulse(10, 10'd4);
        tick(BD + 4 * CPC + 5);
        TR = 1'b1;
        n = 0;
        while (cyc <= t_end + 4 && n < 1000) begin tick(1); n++; end
        TR = 1'b0;
        tick(5);
        check_eq("holdoff_tr_bound", {31'd0, (n < 1000)}, 32'd1);

        // Reset mid-ECHO with TR held high: discard and require a fresh rise.
        trig_pulse(10, 10'd25);
        n = 0;
        while (!exp_ech && n < 1000) begin tick(1); n++; end
        check_eq("echo_start_bound", {31'd0, (n < 1000)}, 32'd1);
        tick(4);
        TR = 1'b1;
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        tick(15);
        TR = 1'b0;
        tick(3);
        trig_pulse(10, 10'd7);         wait_idle(1'b0);

        // Randomized trigger lengths and distances.
        for (int i = 0; i < 30; i++) begin
            logic [9:0] d;
            if ($urandom_range(0, 9) == 0) d = 10'($urandom_range(900, 1023));
            else d = 10'($urandom_range(0, 40));
            trig_pulse($urandom_range(3, 14), d);
            wait_idle(1'($urandom_range(0, 1)));
            tick($urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
